// File: rtl/micro_sequencer.sv
// Microprogram sequencer: microPC, writable control store, return stack and next-address decode.
// mir always holds rom[upc]; the fetch for the next word happens on the same edge that updates upc.
module micro_sequencer #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned OP_W        = 8,
  parameter int unsigned COND_W      = 2,
  parameter int unsigned STACK_DEPTH = 4,
  parameter string       INIT_FILE   = ""
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   restart,
  input  logic [OP_W-1:0]        ir,
  input  logic [2**COND_W-1:0]   flags,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WORD_W-1:0]      wr_data,
  output logic [ADDR_W-1:0]      upc,
  output logic [WORD_W-1:0]      mir,
  output logic                   mir_valid,
  output logic                   halted,
  output logic                   stack_err
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned IR_W  = (OP_W > ADDR_W) ? OP_W : ADDR_W;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [2:0] M_NEXT     = 3'd0;
  localparam logic [2:0] M_JUMP     = 3'd1;
  localparam logic [2:0] M_DISPATCH = 3'd2;
  localparam logic [2:0] M_BRANCH   = 3'd3;
  localparam logic [2:0] M_CALL     = 3'd4;
  localparam logic [2:0] M_RET      = 3'd5;
  localparam logic [2:0] M_HALT     = 3'd6;
  localparam logic [2:0] M_RESTART  = 3'd7;

  logic [WORD_W-1:0] rom [DEPTH];
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] upc_q;
  logic [WORD_W-1:0] mir_q;
  logic              valid_q, err_q;
  logic [SP_W-1:0]   sp_q, sp_d;

  logic              fetch, push, err_set;
  logic [ADDR_W-1:0] nxt, upc_inc, target, ir_addr;
  logic [2:0]        mode;
  logic [COND_W-1:0] csel;
  logic              pol;
  logic [IR_W-1:0]   ir_ext;

  assign target  = mir_q[ADDR_W-1:0];
  assign mode    = mir_q[ADDR_W +: 3];
  assign csel    = mir_q[ADDR_W+3 +: COND_W];
  assign pol     = mir_q[ADDR_W+3+COND_W];
  assign upc_inc = upc_q + ADDR_W'(1);
  assign ir_ext  = IR_W'(ir);
  assign ir_addr = ir_ext[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    fetch   = 1'b0;
    push    = 1'b0;
    err_set = 1'b0;
    nxt     = upc_inc;
    case (state_q)
      ST_BOOT: begin
        fetch   = 1'b1;
        nxt     = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        fetch = 1'b1;
        case (mode)
          M_NEXT:     nxt = upc_inc;
          M_JUMP:     nxt = target;
          M_DISPATCH: nxt = ir_addr;
          M_BRANCH:   nxt = (flags[csel] ^ pol) ? target : upc_inc;
          M_CALL: begin
            nxt = target;
            if (sp_q == SP_W'(STACK_DEPTH)) begin
              err_set = 1'b1;
            end else begin
              push = 1'b1;
              sp_d = sp_q + SP_W'(1);
            end
          end
          M_RET: begin
            if (sp_q == '0) begin
              nxt     = '0;
              err_set = 1'b1;
            end else begin
              nxt  = stack_q[IDX_W'(sp_q - SP_W'(1))];
              sp_d = sp_q - SP_W'(1);
            end
          end
          M_HALT: begin
            fetch   = 1'b0;
            state_d = ST_HALT;
          end
          M_RESTART: begin
            nxt  = '0;
            sp_d = '0;
          end
          default: nxt = upc_inc;
        endcase
      end
      ST_HALT: begin
        if (restart) begin
          fetch   = 1'b1;
          nxt     = '0;
          sp_d    = '0;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      upc_q   <= '0;
      mir_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      sp_q    <= '0;
    end else if (!stall) begin
      state_q <= state_d;
      sp_q    <= sp_d;
      if (err_set) err_q <= 1'b1;
      if (fetch) begin
        upc_q   <= nxt;
        mir_q   <= rom[nxt];
        valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!stall && push) stack_q[IDX_W'(sp_q)] <= upc_inc;
  end

  // Non-blocking write gives read-first behaviour against the fetch above.
  always_ff @(posedge clk) begin
    if (wr_en) rom[wr_addr] <= wr_data;
  end

  assign upc       = upc_q;
  assign mir       = mir_q;
  assign mir_valid = valid_q;
  assign halted    = (state_q == ST_HALT);
  assign stack_err = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed table-driven bench for micro_sequencer with default parameters.
module tb_micro_sequencer;

  logic        clk, rst_n, stall, restart, wr_en;
  logic [7:0]  ir, wr_addr, upc;
  logic [3:0]  flags;
  logic [31:0] wr_data, mir;
  logic        mir_valid, halted, stack_err;

  micro_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .restart(restart), .ir(ir), .flags(flags),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .upc(upc), .mir(mir),
    .mir_valid(mir_valid), .halted(halted), .stack_err(stack_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       st, rs, we;
    logic [3:0] fl;
    logic [7:0] irv, wa, e_upc;
    logic [31:0] wd;
    logic       e_halt, e_err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model [256];
  int          checks = 0;
  int          errors = 0;
  string       phase;

  localparam int NEXT = 0, JUMP = 1, DISP = 2, BR = 3, CALL = 4, RET = 5, HLT = 6;

  function automatic logic [31:0] mw(input int mode, input int tgt, input int csel = 0,
                                     input int pol = 0);
    logic [31:0] w;
    w = '0;
    w[31:14] = 18'h2B5C1 ^ 18'(tgt);
    w[13]    = pol[0];
    w[12:11] = csel[1:0];
    w[10:8]  = mode[2:0];
    w[7:0]   = tgt[7:0];
    return w;
  endfunction

  function automatic vec_t v(input logic [7:0] e_upc, input logic e_halt, input logic e_err,
                             input logic st = 0, input logic rs = 0, input logic [3:0] fl = 0,
                             input logic [7:0] irv = 0, input logic we = 0,
                             input logic [7:0] wa = 0, input logic [31:0] wd = 0);
    vec_t r;
    r.e_upc = e_upc; r.e_halt = e_halt; r.e_err = e_err; r.st = st; r.rs = rs;
    r.fl = fl; r.irv = irv; r.we = we; r.wa = wa; r.wd = wd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", phase, nm, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    model[a] = d;
  endtask

  task automatic do_reset(input bit check_zero);
    rst_n = 1'b0;
    #1;
    if (check_zero) begin
      chk("async upc", 32'(upc), 0);
      chk("async mir", mir, 0);
      chk("async valid", 32'(mir_valid), 0);
      chk("async halted", 32'(halted), 0);
      chk("async err", 32'(stack_err), 0);
    end
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    #1;
    chk("pre-boot valid", 32'(mir_valid), 0);
    chk("pre-boot upc", 32'(upc), 0);
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) begin
      stall = vecs[i].st; restart = vecs[i].rs; flags = vecs[i].fl; ir = vecs[i].irv;
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      @(posedge clk); #1;
      chk($sformatf("v%0d upc", i), 32'(upc), 32'(vecs[i].e_upc));
      chk($sformatf("v%0d mir", i), mir, model[vecs[i].e_upc]);
      chk($sformatf("v%0d valid", i), 32'(mir_valid), 1);
      chk($sformatf("v%0d halted", i), 32'(halted), 32'(vecs[i].e_halt));
      chk($sformatf("v%0d err", i), 32'(stack_err), 32'(vecs[i].e_err));
      if (vecs[i].we) model[vecs[i].wa] = vecs[i].wd;
    end
    stall = 0; restart = 0; flags = 0; ir = 0; wr_en = 0;
    vecs.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = '0;
    rst_n = 0; stall = 0; restart = 0; ir = 0; flags = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;

    // Phase 1: sequencing, dispatch with stall, branches, nested calls, empty return.
    phase = "p1";
    #2;
    wr(8'h00, mw(NEXT, 0));       wr(8'h01, mw(JUMP, 8'h10));
    wr(8'h10, mw(JUMP, 8'h02));   wr(8'h02, mw(DISP, 0));
    wr(8'h2A, mw(JUMP, 8'h05));   wr(8'h05, mw(BR, 8'h15, 0, 0));
    wr(8'h15, mw(JUMP, 8'h05));   wr(8'h06, mw(BR, 8'h17, 1, 1));
    wr(8'h17, mw(BR, 8'h19, 1, 1)); wr(8'h18, mw(JUMP, 8'h20));
    wr(8'h20, mw(CALL, 8'h30));   wr(8'h30, mw(CALL, 8'h40));
    wr(8'h40, mw(CALL, 8'h50));   wr(8'h50, mw(CALL, 8'h60));
    wr(8'h60, mw(RET, 0));        wr(8'h51, mw(RET, 0));
    wr(8'h41, mw(RET, 0));        wr(8'h31, mw(RET, 0));
    wr(8'h21, mw(RET, 0));
    release_reset();
    vecs.push_back(v(8'h00, 0, 0));
    vecs.push_back(v(8'h01, 0, 0, 0, 1));        // restart ignored while running
    vecs.push_back(v(8'h10, 0, 0));
    vecs.push_back(v(8'h02, 0, 0));
    for (int k = 0; k < 3; k++) vecs.push_back(v(8'h02, 0, 0, 1, 0, 4'h0, 8'h2A));
    vecs.push_back(v(8'h2A, 0, 0, 0, 0, 4'h0, 8'h2A));
    vecs.push_back(v(8'h05, 0, 0));
    vecs.push_back(v(8'h15, 0, 0, 0, 0, 4'h1));  // Z=1, pol=0: taken
    vecs.push_back(v(8'h05, 0, 0));
    vecs.push_back(v(8'h06, 0, 0, 0, 0, 4'h0));  // Z=0, pol=0: fall through
    vecs.push_back(v(8'h17, 0, 0, 0, 0, 4'h0));  // flags[1]=0, pol=1: taken
    vecs.push_back(v(8'h18, 0, 0, 0, 0, 4'h2));  // flags[1]=1, pol=1: fall through
    vecs.push_back(v(8'h20, 0, 0));
    vecs.push_back(v(8'h30, 0, 0));
    vecs.push_back(v(8'h40, 0, 0));
    vecs.push_back(v(8'h50, 0, 0));
    vecs.push_back(v(8'h60, 0, 0));
    vecs.push_back(v(8'h51, 0, 0));
    vecs.push_back(v(8'h41, 0, 0));
    vecs.push_back(v(8'h31, 0, 0));
    vecs.push_back(v(8'h21, 0, 0));
    vecs.push_back(v(8'h00, 0, 1));              // RET on empty stack
    vecs.push_back(v(8'h01, 0, 1));
    run_vecs();

    // Phase 2: stack overflow, halt hold, stall over restart, restart clears the stack.
    phase = "p2";
    do_reset(1);
    wr(8'h00, mw(JUMP, 8'h80));
    wr(8'h80, mw(CALL, 8'h81));   wr(8'h81, mw(CALL, 8'h82));
    wr(8'h82, mw(CALL, 8'h83));   wr(8'h83, mw(CALL, 8'h84));
    wr(8'h84, mw(CALL, 8'h90));   wr(8'h90, mw(JUMP, 8'h07));
    wr(8'h07, mw(HLT, 0));
    release_reset();
    vecs.push_back(v(8'h00, 0, 0));
    vecs.push_back(v(8'h80, 0, 0));
    vecs.push_back(v(8'h81, 0, 0));
    vecs.push_back(v(8'h82, 0, 0));
    vecs.push_back(v(8'h83, 0, 0));
    vecs.push_back(v(8'h84, 0, 0));
    vecs.push_back(v(8'h90, 0, 1));              // fifth CALL: jump taken, error set
    vecs.push_back(v(8'h07, 0, 1));
    vecs.push_back(v(8'h07, 1, 1));
    vecs.push_back(v(8'h07, 1, 1, 0, 0, 4'h0, 8'h00, 1, 8'h00, mw(RET, 0)));
    for (int k = 0; k < 3; k++) vecs.push_back(v(8'h07, 1, 1));
    vecs.push_back(v(8'h07, 1, 1, 1, 1));        // stall beats restart
    for (int k = 0; k < 4; k++) vecs.push_back(v(8'h07, 1, 1));
    vecs.push_back(v(8'h00, 0, 1, 0, 1));
    vecs.push_back(v(8'h00, 0, 1));              // stack empty: RET gives 0, not 0x84
    vecs.push_back(v(8'h00, 0, 1));
    run_vecs();

    // Phase 3: read-first write collision, then asynchronous reset mid-run.
    phase = "p3";
    do_reset(1);
    wr(8'h00, mw(JUMP, 8'h33));
    wr(8'h33, mw(NEXT, 8'h33));
    wr(8'h34, mw(JUMP, 8'h33));
    release_reset();
    vecs.push_back(v(8'h00, 0, 0));
    vecs.push_back(v(8'h33, 0, 0, 0, 0, 4'h0, 8'h00, 1, 8'h33, mw(JUMP, 8'h00)));
    vecs.push_back(v(8'h34, 0, 0));
    vecs.push_back(v(8'h33, 0, 0));
    vecs.push_back(v(8'h00, 0, 0));
    vecs.push_back(v(8'h33, 0, 0));
    run_vecs();

    phase = "p4";
    do_reset(1);
    release_reset();
    @(posedge clk); #1;
    chk("reboot upc", 32'(upc), 0);
    chk("reboot mir", mir, model[0]);
    chk("reboot valid", 32'(mir_valid), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
